// File: rtl/hangman_engine.sv
// Hangman game engine: fetches a word from an external ROM, scans guesses one letter per cycle,
// and tracks found letters and wrong tries. Optional used-letter history via GUESS_HISTORY_EN.
module hangman_engine #(
    parameter int WORD_LEN  = 5,
    parameter int CHAR_W    = 5,
    parameter int MAX_TRIES = 7,
    parameter int ROM_AW    = 6,
    localparam int TRY_W    = $clog2(MAX_TRIES + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       guess_valid,
    input  logic [CHAR_W-1:0]          guess_char,
    output logic                       guess_ready,
    output logic [ROM_AW-1:0]          rom_addr,
    input  logic [WORD_LEN*CHAR_W-1:0] rom_data,
    output logic [WORD_LEN-1:0]        found,
    output logic [TRY_W-1:0]           tries_used,
    output logic                       guess_done,
    output logic                       guess_hit,
    output logic                       win,
    output logic                       lose,
    output logic                       busy
);
    localparam int IDX_W = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, FETCH, WAIT, SCAN, RESOLVE, WIN, LOSE} state_t;

    state_t                     state_reg, state_next;
    logic [15:0]                lfsr_reg;
    logic [WORD_LEN*CHAR_W-1:0] word_reg;
    logic [CHAR_W-1:0]          char_reg;
    logic [IDX_W-1:0]           idx_reg;
    logic [WORD_LEN-1:0]        found_reg;
    logic [TRY_W-1:0]           tries_reg;
    logic                       hit_reg;
    logic                       win_reg;
    logic                       lose_reg;
    logic [ROM_AW-1:0]          rom_addr_reg;

    logic [CHAR_W-1:0]          letter [WORD_LEN];
    logic                       idx_last;
    logic                       all_found;
    logic [TRY_W-1:0]           tries_inc;
    logic                       skip_reg;
    logic                       seen;

    genvar gi;
    generate
        for (gi = 0; gi < WORD_LEN; gi++) begin : g_letter
            assign letter[gi] = word_reg[gi*CHAR_W +: CHAR_W];
        end
    endgenerate

    assign idx_last  = (idx_reg == IDX_W'(WORD_LEN - 1));
    assign all_found = &found_reg;
    assign tries_inc = (tries_reg == TRY_W'(MAX_TRIES)) ? tries_reg : tries_reg + TRY_W'(1);

`ifdef GUESS_HISTORY_EN
    // One bit per possible letter code; a repeated letter resolves immediately without a scan.
    logic [2**CHAR_W-1:0] mask_reg;

    assign seen = mask_reg[guess_char];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask_reg <= '0;
            skip_reg <= 1'b0;
        end else begin
            if (state_reg == LOAD)
                mask_reg <= '0;
            else if (state_reg == RESOLVE && !skip_reg)
                mask_reg[char_reg] <= 1'b1;
            if (state_reg == WAIT && guess_valid)
                skip_reg <= seen;
        end
    end
`else
    assign seen     = 1'b0;
    assign skip_reg = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, WIN, LOSE: if (start) state_next = LOAD;
            LOAD:            state_next = FETCH;
            FETCH:           state_next = WAIT;
            WAIT:            if (guess_valid) state_next = seen ? RESOLVE : SCAN;
            SCAN:            if (idx_last) state_next = RESOLVE;
            RESOLVE: begin
                if (skip_reg)                         state_next = WAIT;
                else if (hit_reg && all_found)        state_next = WIN;
                else if (hit_reg)                     state_next = WAIT;
                else if (tries_inc == TRY_W'(MAX_TRIES)) state_next = LOSE;
                else                                  state_next = WAIT;
            end
            default:         state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_reg     <= 16'h0001;
            word_reg     <= '0;
            char_reg     <= '0;
            idx_reg      <= '0;
            found_reg    <= '0;
            tries_reg    <= '0;
            hit_reg      <= 1'b0;
            win_reg      <= 1'b0;
            lose_reg     <= 1'b0;
            rom_addr_reg <= '0;
        end else begin
            lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[14] ^ lfsr_reg[12] ^ lfsr_reg[3]};
            case (state_reg)
                IDLE, WIN, LOSE: begin
                    if (start) begin
                        found_reg <= '0;
                        tries_reg <= '0;
                        hit_reg   <= 1'b0;
                        win_reg   <= 1'b0;
                        lose_reg  <= 1'b0;
                    end
                end
                LOAD:  rom_addr_reg <= lfsr_reg[ROM_AW-1:0];
                FETCH: word_reg <= rom_data;
                WAIT: begin
                    if (guess_valid) begin
                        char_reg <= guess_char;
                        idx_reg  <= '0;
                        hit_reg  <= 1'b0;
                    end
                end
                SCAN: begin
                    if (letter[idx_reg] == char_reg) begin
                        found_reg[idx_reg] <= 1'b1;
                        hit_reg            <= 1'b1;
                    end
                    if (!idx_last) idx_reg <= idx_reg + IDX_W'(1);
                end
                RESOLVE: begin
                    if (!skip_reg) begin
                        if (hit_reg && all_found) begin
                            win_reg <= 1'b1;
                        end else if (!hit_reg) begin
                            tries_reg <= tries_inc;
                            if (tries_inc == TRY_W'(MAX_TRIES)) lose_reg <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign guess_ready = (state_reg == WAIT);
    assign guess_done  = (state_reg == RESOLVE);
    assign guess_hit   = hit_reg;
    assign busy        = (state_reg == LOAD) || (state_reg == FETCH) ||
                         (state_reg == SCAN) || (state_reg == RESOLVE);
    assign rom_addr    = rom_addr_reg;
    assign found       = found_reg;
    assign tries_used  = tries_reg;
    assign win         = win_reg;
    assign lose        = lose_reg;

endmodule

// File: tb/tb_hangman_engine.sv
// Directed bench for hangman_engine: reset, win on "HELLO", lose on repeated misses,
// guess latency, start/guess legality, restart from LOSE and reset during a scan.
module tb_hangman_engine;
    localparam int WL = 5;
    localparam int CW = 5;
    localparam int AW = 6;
    localparam int TW = 3;
`ifdef GUESS_HISTORY_EN
    localparam bit HIST = 1'b1;
`else
    localparam bit HIST = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          guess_valid = 1'b0;
    logic [CW-1:0] guess_char = '0;
    logic          guess_ready;
    logic [AW-1:0] rom_addr;
    logic [WL*CW-1:0] rom_data;
    logic [WL-1:0] found;
    logic [TW-1:0] tries_used;
    logic          guess_done;
    logic          guess_hit;
    logic          win;
    logic          lose;
    logic          busy;

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] m_lfsr;
    logic [AW-1:0] exp_addr;
    int lat;

    // "HELLO": H=7, E=4, L=11, L=11, O=14, letter 0 in the low bits
    assign rom_data = {5'd14, 5'd11, 5'd11, 5'd4, 5'd7};

    always #5 clk = ~clk;

    // Reference LFSR, taps 16,15,13,4, seeded with 1
    always @(posedge clk or negedge rst) begin
        if (!rst) m_lfsr <= 16'h0001;
        else      m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[14] ^ m_lfsr[12] ^ m_lfsr[3]};
    end

    hangman_engine dut (
        .clk(clk), .rst(rst), .start(start), .guess_valid(guess_valid),
        .guess_char(guess_char), .guess_ready(guess_ready), .rom_addr(rom_addr),
        .rom_data(rom_data), .found(found), .tries_used(tries_used),
        .guess_done(guess_done), .guess_hit(guess_hit), .win(win), .lose(lose), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the guess_done cycle with the
    // number of cycles since the handshake cycle.
    task automatic guess(input logic [CW-1:0] c, input bit hold, input logic [CW-1:0] hc,
                         output int l);
        int w;
        w = 0;
        while (!guess_ready && w < 40) begin @(negedge clk); w++; end
        check("ready_before_guess", guess_ready, 1);
        guess_valid = 1'b1;
        guess_char  = c;
        @(negedge clk);
        l = 1;
        if (hold) guess_char = hc;
        else      guess_valid = 1'b0;
        while (!guess_done && l < 40) begin
            if (hold) check("ready_low_in_scan", guess_ready, 0);
            @(negedge clk);
            l++;
        end
        guess_valid = 1'b0;
    endtask

    task automatic start_game(input string tag);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_load"}, busy, 1);
        check({tag, "_found_clr"}, found, 0);
        check({tag, "_tries_clr"}, tries_used, 0);
        check({tag, "_win_clr"}, win, 0);
        check({tag, "_lose_clr"}, lose, 0);
        exp_addr = m_lfsr[AW-1:0];
        @(negedge clk);
        check({tag, "_rom_addr"}, rom_addr, exp_addr);
        @(negedge clk);
        check({tag, "_ready_wait"}, guess_ready, 1);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", guess_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_addr", rom_addr, 0);
        rst = 1'b1;
        #1;
        check("rst_lfsr", dut.lfsr_reg, 16'h0001);
        @(negedge clk);
        check("idle_ready", guess_ready, 0);

        // Win game on HELLO
        start_game("g1");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_in_wait_ignored", guess_ready, 1);
        check("start_in_wait_busy", busy, 0);

        guess(5'd7, 1'b1, 5'd4, lat);
        check("lat_h", lat, WL + 1);
        check("done_h", guess_done, 1);
        check("hit_h", guess_hit, 1);
        @(negedge clk);
        check("found_h", found, 5'b00001);
        check("ready_after_h", guess_ready, 1);
        check("tries_h", tries_used, 0);

        guess(5'd7, 1'b0, 5'd0, lat);
        check("lat_rep_h", lat, HIST ? 1 : WL + 1);
        check("hit_rep_h", guess_hit, HIST ? 0 : 1);
        @(negedge clk);
        check("found_rep_h", found, 5'b00001);
        check("tries_rep_h", tries_used, 0);

        guess(5'd4, 1'b0, 5'd0, lat);
        check("hit_e", guess_hit, 1);
        @(negedge clk);
        check("found_e", found, 5'b00011);

        guess(5'd11, 1'b0, 5'd0, lat);
        check("hit_l", guess_hit, 1);
        @(negedge clk);
        check("found_l", found, 5'b01111);

        guess(5'd14, 1'b0, 5'd0, lat);
        check("lat_o", lat, WL + 1);
        check("hit_o", guess_hit, 1);
        check("win_not_yet", win, 0);
        @(negedge clk);
        check("found_o", found, 5'b11111);
        check("win", win, 1);
        check("win_tries", tries_used, 0);
        check("win_ready", guess_ready, 0);
        check("win_busy", busy, 0);

        // Lose game: seven wrong guesses
        start_game("g2");
        for (int i = 0; i < 7; i++) begin
            guess(HIST ? CW'(25 + i) : 5'd25, 1'b0, 5'd0, lat);
            check("miss_lat", lat, WL + 1);
            check("miss_hit", guess_hit, 0);
            @(negedge clk);
            check("miss_tries", tries_used, i + 1);
            check("miss_lose", lose, (i == 6) ? 1 : 0);
            if (HIST && i == 0) begin
                guess(5'd25, 1'b0, 5'd0, lat);
                check("hist_lat", lat, 1);
                check("hist_hit", guess_hit, 0);
                @(negedge clk);
                check("hist_tries", tries_used, 1);
            end
        end
        check("lose_ready", guess_ready, 0);
        check("lose_busy", busy, 0);
        guess_valid = 1'b1;
        guess_char  = 5'd26;
        repeat (3) @(negedge clk);
        guess_valid = 1'b0;
        check("lose_guess_ignored", tries_used, 7);
        check("lose_held", lose, 1);

        // Restart from LOSE
        start_game("g3");

        // Reset in the middle of a scan
        guess_valid = 1'b1;
        guess_char  = 5'd11;
        @(negedge clk);
        guess_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_busy", busy, 1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_found", found, 0);
        check("mid_rst_tries", tries_used, 0);
        check("mid_rst_addr", rom_addr, 0);
        check("mid_rst_done", guess_done, 0);
        check("mid_rst_hit", guess_hit, 0);
        check("mid_rst_ready", guess_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rerst_lfsr", dut.lfsr_reg, 16'h0001);
        repeat (2) @(negedge clk);
        check("rerst_idle_ready", guess_ready, 0);
        check("rerst_idle_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
